wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Parametrised MEM/WB pipeline register plus writeback select for the RISC-V pipeline.
//   Captures one retiring instruction per cycle and aligns and extends load data.
//   Selects the register-file write value from mem/alu/pc+4/aux.
//   Drives the regfile write port one cycle after capture.
// PARAMETERS
//   XLEN      32   datapath width; legal values 32 or 64 (64 enables LD/LWU)
//   OFS_W     $clog2(XLEN/8)   byte-offset bits taken from alu[OFS_W-1:0] (derived)
// PORTS
//   clk          in   1     clock, rising edge
//   rst_n        in   1     asynchronous reset, active low
//   stall        in   1     hold WB register contents
//   flush        in   1     kill the instruction being captured / held
//   in_valid     in   1     MEM stage presents a valid instruction
//   in_regwrite  in   1     instruction writes rd
//   in_rd        in   5     destination register
//   in_wb_sel    in   2     00 mem, 01 alu, 10 pc_add4, 11 aux
//   in_funct3    in   3     load size/sign (used only when in_wb_sel==00)
//   mem_rdata    in   XLEN  raw naturally-aligned memory read word
//   alu          in   XLEN  ALU result / load effective address
//   pc_add4      in   XLEN  PC+4 of the instruction
//   aux          in   XLEN  CSR read / LUI immediate path
//   wb_valid     out  1     WB register holds a live instruction
//   wb_we        out  1     regfile write enable
//   wb_rd        out  5     regfile write address
//   wb_data      out  XLEN  regfile write data
//   wb_misalign  out  1     held load was misaligned (trap request)
// BEHAVIOUR
//   - Reset (rst_n=0, async): all outputs and internal registers 0.
//   - Capture at posedge when !stall: valid_q<=in_valid&!flush; rd/sel/data regs load.
//   - stall=1: all registers hold. flush=1: valid_q<=0 regardless of stall (flush wins).
//   - Latency: 1 cycle, input at edge N -> outputs valid after edge N.
//   - Outputs are registered; no combinational path from inputs to outputs.
//   - Load extraction (sel 00), computed before the register; b = byte at offset alu[OFS_W-1:0]:
//     000 LB  sign-ext byte     100 LBU zero-ext byte
//     001 LH  sign-ext half     101 LHU zero-ext half
//     010 LW  word (sign-ext to XLEN when 64)    110 LWU zero-ext word (XLEN=64 only)
//     011 LD  full dword (XLEN=64 only)
//     Any other funct3, or 011/110 at XLEN=32, is treated as LW.
//   - Misalign: half at odd offset, word at offset%4!=0, dword at offset!=0.
//     On misalign: wb_misalign=1, wb_we=0, wb_data=0.
//   - wb_we = valid_q & regwrite_q & (rd_q!=0) & !misalign_q; writes to x0 never assert.
//   - wb_rd/wb_data are meaningful only when wb_we=1; otherwise they hold the last captured values.
//   - wb_misalign is qualified by valid_q (0 when wb_valid=0).
//   - Reset mid-stall: registers clear; the next capture proceeds normally.
// CONFIGURATION
//   WB_RETIRE_CNT_EN defined: adds output instret [63:0] (reset 0).
//     instret increments by 1 each cycle wb_valid=1 & !wb_misalign & !stall_q,
//     where stall_q is stall registered with the capture, so each instruction counts once.
//     Wraps from 2^64-1 to 0.
//   WB_RETIRE_CNT_EN undefined: no instret port and no counter logic.
// TESTING
//   1. rst_n=0 with random inputs -> all outputs 0; release -> still 0 until first capture.
//   2. sel=01, alu=32'h1234_5678, rd=5, regwrite=1 -> next cycle wb_we=1, wb_rd=5, wb_data=32'h12345678.
//   3. sel=00, mem_rdata=32'h80FF_7F01: LB ofs3 -> FFFFFF80; LBU ofs1 -> 0000007F; LH ofs2 -> FFFF80FF.
//   4. LH at alu=32'h1001 -> wb_misalign=1, wb_we=0; LW at rd=0 -> wb_we=0, no misalign.
//   5. Capture, then stall=1 for 3 cycles with changed inputs -> outputs frozen.
//      stall=1 & flush=1 -> wb_valid=0 next cycle.
//   6. WB_RETIRE_CNT_EN: 10 valid instrs incl. 1 misaligned and 2 stall cycles -> instret=9.
//      Preload near max -> wraps to 0.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register with load alignment/extension and writeback select.
// Optional retired-instruction counter (output instret) is enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int XLEN = 32,
    localparam int OFS_W = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_regwrite,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [XLEN-1:0] alu,
    input  logic [XLEN-1:0] pc_add4,
    input  logic [XLEN-1:0] aux,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]     instret,
`endif
    output logic            wb_misalign
);
    logic [OFS_W-1:0] ofs;
    logic [XLEN-1:0]  sh, ld, nxt_data;
    logic [1:0]       sz;
    logic             uns, mis, nxt_mis;
    logic             valid_q, regwrite_q, misalign_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  data_q;

    // Shift the addressed lane to bit 0, then size/sign-extend; sz: 0 byte, 1 half, 2 word, 3 dword.
    always_comb begin
        ofs      = alu[OFS_W-1:0];
        sh       = mem_rdata >> {ofs, 3'b000};
        sz       = in_funct3[1:0] == 2'b00 ? 2'd0 :
                   in_funct3[1:0] == 2'b01 ? 2'd1 :
                   (XLEN == 64 && in_funct3 == 3'b011) ? 2'd3 : 2'd2;
        uns      = in_funct3 == 3'b100 || in_funct3 == 3'b101 || (XLEN == 64 && in_funct3 == 3'b110);
        mis      = sz == 2'd1 ? ofs[0] : sz == 2'd2 ? |ofs[1:0] : sz == 2'd3 ? |ofs : 1'b0;
        ld       = sz == 2'd0 ? (uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
                   sz == 2'd1 ? (uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
                   sz == 2'd2 ? (uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
        nxt_mis  = in_wb_sel == 2'b00 && mis;
        nxt_data = nxt_mis ? '0 :
                   in_wb_sel == 2'b00 ? ld :
                   in_wb_sel == 2'b01 ? alu :
                   in_wb_sel == 2'b10 ? pc_add4 : aux;
    end

    // WB register: payload holds on stall; flush always kills the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
        end else begin
            if (!stall) begin
                regwrite_q <= in_regwrite;
                misalign_q <= nxt_mis;
                rd_q       <= in_rd;
                data_q     <= nxt_data;
            end
            valid_q <= flush ? 1'b0 : stall ? valid_q : in_valid;
        end
    end

    assign wb_valid    = valid_q;
    assign wb_we       = valid_q & regwrite_q & (rd_q != 5'd0) & ~misalign_q;
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign wb_misalign = valid_q & misalign_q;

`ifdef WB_RETIRE_CNT_EN
    logic stall_q;

    // Count each live, trap-free instruction once: held (stalled) cycles are skipped via stall_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            instret <= '0;
        end else begin
            stall_q <= stall;
            instret <= instret + 64'(valid_q & ~misalign_q & ~stall_q);
        end
    end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized and directed self-checking bench for wb_stage against a behavioural model.
module tb_wb_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            stall = 1'b0, flush = 1'b0, in_valid = 1'b0, in_regwrite = 1'b0;
    logic [4:0]      in_rd = '0;
    logic [1:0]      in_wb_sel = '0;
    logic [2:0]      in_funct3 = '0;
    logic [XLEN-1:0] mem_rdata = '0, alu = '0, pc_add4 = '0, aux = '0;
    logic            wb_valid, wb_we, wb_misalign;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0]     instret;
`endif

    wb_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .mem_rdata(mem_rdata),
        .alu(alu), .pc_add4(pc_add4), .aux(aux),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef WB_RETIRE_CNT_EN
        .instret(instret),
`endif
        .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    logic        m_valid = 0, m_rw = 0, m_mis = 0, m_pend = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_data = 0;
    logic [63:0] m_instret = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference writeback value and misalign flag, from the load table with plain arithmetic.
    function automatic logic [32:0] ref_wb(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [31:0] mem, input logic [31:0] a,
                                           input logic [31:0] pc, input logic [31:0] x);
        int ofs = int'(a % 4);
        logic [31:0] w = mem >> (8 * ofs);
        logic [31:0] v;
        logic m = 0;
        if (sel == 1) v = a;
        else if (sel == 2) v = pc;
        else if (sel == 3) v = x;
        else begin
            case (f3)
                3'd0: begin v = w % 256; if (v >= 128) v = v + 32'hFFFF_FF00; end
                3'd4: v = w % 256;
                3'd1: begin m = (ofs % 2) != 0; v = w % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
                3'd5: begin m = (ofs % 2) != 0; v = w % 65536; end
                default: begin m = ofs != 0; v = w; end
            endcase
            if (m) v = 0;
        end
        return {m, v};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mis = 0; m_pend = 0; m_rd = 0; m_data = 0; m_instret = 0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
        check({tag, ".we"}, 64'(wb_we), 64'(m_valid & m_rw & (m_rd != 0) & !m_mis));
        check({tag, ".rd"}, 64'(wb_rd), 64'(m_rd));
        check({tag, ".data"}, 64'(wb_data), 64'(m_data));
        check({tag, ".mis"}, 64'(wb_misalign), 64'(m_valid & m_mis));
`ifdef WB_RETIRE_CNT_EN
        check({tag, ".instret"}, instret, m_instret);
`endif
    endtask

    task automatic step(input string tag);
        logic [32:0] r;
        @(posedge clk);
        if (rst_n) begin
            m_instret = m_instret + 64'(m_pend);
            if (!stall) begin
                r      = ref_wb(in_wb_sel, in_funct3, mem_rdata, alu, pc_add4, aux);
                m_mis  = r[32];
                m_data = r[31:0];
                m_rd   = in_rd;
                m_rw   = in_regwrite;
            end
            m_pend  = !stall & in_valid & !flush & !(!stall & m_mis);
            m_valid = flush ? 1'b0 : stall ? m_valid : in_valid;
        end
        #1;
        check_outs(tag);
    endtask

    task automatic set(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] mem, input logic [31:0] a);
        in_valid = v; in_regwrite = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        mem_rdata = mem; alu = a; pc_add4 = $urandom; aux = $urandom;
    endtask

    task automatic randomize_inputs();
        set(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 0;
        randomize_inputs();
        stall = 1'($urandom); flush = 1'($urandom);
        #1;
        model_reset();
        check_outs("rst");
        @(negedge clk);
        check_outs("rst_hold");
        set(0, 0, 0, 0, 0, 0, 0); pc_add4 = 0; aux = 0; stall = 0; flush = 0;
        rst_n = 1;
        step("rst_rel");
    endtask

    initial begin
        do_reset();

        set(1, 1, 5, 2'b01, 0, 0, 32'h1234_5678);
        step("alu");
        check("alu.we_const", 64'(wb_we), 64'd1);
        check("alu.data_const", 64'(wb_data), 64'h1234_5678);

        set(1, 1, 3, 2'b00, 3'd0, 32'h80FF_7F01, 32'h3);
        step("lb");
        check("lb.const", 64'(wb_data), 64'hFFFF_FF80);
        set(1, 1, 3, 2'b00, 3'd4, 32'h80FF_7F01, 32'h1);
        step("lbu");
        check("lbu.const", 64'(wb_data), 64'h0000_007F);
        set(1, 1, 3, 2'b00, 3'd1, 32'h80FF_7F01, 32'h2);
        step("lh");
        check("lh.const", 64'(wb_data), 64'hFFFF_80FF);

        set(1, 1, 7, 2'b00, 3'd1, $urandom, 32'h1001);
        step("lh_mis");
        check("lh_mis.flag", 64'(wb_misalign), 64'd1);
        check("lh_mis.we", 64'(wb_we), 64'd0);
        set(1, 1, 0, 2'b00, 3'd2, $urandom, 32'h100);
        step("lw_x0");
        check("lw_x0.we", 64'(wb_we), 64'd0);
        check("lw_x0.mis", 64'(wb_misalign), 64'd0);

        set(1, 1, 9, 2'b01, 0, 0, 32'hAAAA);
        step("pre_stall");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step("stall");
            check("stall.frozen", 64'(wb_data), 64'hAAAA);
        end
        flush = 1;
        step("stall_flush");
        check("stall_flush.valid", 64'(wb_valid), 64'd0);
        flush = 0; stall = 0;

        set(1, 1, 4, 2'b11, 0, 0, 0);
        step("pre_rst");
        stall = 1;
        randomize_inputs();
        step("rst_stall");
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        check_outs("rst_mid");
        @(negedge clk);
        rst_n = 1; stall = 0;
        set(1, 1, 12, 2'b01, 0, 0, 32'h55);
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            step("rand");
        end
        stall = 0; flush = 0;

`ifdef WB_RETIRE_CNT_EN
        do_reset();
        for (int i = 0; i < 12; i++) begin
            stall = (i == 3 || i == 8);
            if (i == 5) set(1, 1, 1, 2'b00, 3'd1, $urandom, 32'h1);
            else set(1, 1, 1, 2'b01, 0, 0, $urandom);
            step("cnt");
        end
        stall = 0;
        set(0, 0, 0, 2'b01, 0, 0, 0);
        step("cnt_idle");
        step("cnt_idle");
        check("cnt.nine", instret, 64'd9);
        @(negedge clk);
        dut.instret = 64'hFFFF_FFFF_FFFF_FFFE;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        set(1, 1, 2, 2'b01, 0, 0, 1);
        step("wrap");
        step("wrap");
        set(0, 0, 0, 2'b01, 0, 0, 0);
        step("wrap_idle");
        check("wrap.zero", instret, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
